// File: rtl/hazard_unit.sv
// hazard_unit -- operand forwarding and load-use interlock for stage 3.
//
// Tracks the destination registers of the instructions in pipeline
// stages 4..7 (slots S4..S7) and, for each source operand of the
// instruction in stage 3, either forwards the newest in-flight value or
// requests a hold when that value does not exist yet (load still in
// flight).
//
// Ports:
//   clk_i                 clock, rising-edge
//   rst_i                 asynchronous active-high reset
//   stall_i               global freeze: tracking table and counter hold
//   id_valid_i            stage-3 instruction present
//   id_rs1_i, id_rs2_i    stage-3 source register indices
//   id_uses_rs1_i/_rs2_i  stage-3 instruction reads rs1 / rs2
//   id_writes_rd_i        stage-3 instruction writes id_rd_i
//   id_rd_i               stage-3 destination index
//   id_is_load_i          stage-3 instruction is a load
//   eval_i                ALU result of the instruction in S4
//   mem_rdata_i           load data of the instruction in S6
//   bypass_o              bit0 = rs1 forwarded, bit1 = rs2 forwarded
//   rs1/rs2_bypass_value_o forwarded operand values
//   hazard_stall_o        stage 3 must hold this cycle
//   hazard_count_o        saturating count of issued hazard stalls
module hazard_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_uses_rs1_i,
  input  logic        id_uses_rs2_i,
  input  logic        id_writes_rd_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_is_load_i,
  input  logic [31:0] eval_i,
  input  logic [31:0] mem_rdata_i,
  output logic [1:0]  bypass_o,
  output logic [31:0] rs1_bypass_value_o,
  output logic [31:0] rs2_bypass_value_o,
  output logic        hazard_stall_o,
  output logic [15:0] hazard_count_o
);

  // Slot index 0..3 corresponds to S4..S7 (index 0 is the youngest).
  localparam int NSLOT = 4;

  logic        valid_q [NSLOT];
  logic        valid_d [NSLOT];
  logic [4:0]  rd_q    [NSLOT];
  logic [4:0]  rd_d    [NSLOT];
  logic        load_q  [NSLOT];
  logic        load_d  [NSLOT];
  logic [31:0] value_q [NSLOT];
  logic [31:0] value_d [NSLOT];
  logic [15:0] count_q;
  logic [15:0] count_d;

  // Value each slot would forward right now, and whether it is final.
  logic [31:0] eff_value [NSLOT];
  logic        ready     [NSLOT];

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
    if (gi == 0) begin : g_s4
      // S4 never stores its result; the registered ALU output is it.
      assign eff_value[gi] = eval_i;
      assign ready[gi]     = !load_q[gi];
    end else if (gi == 2) begin : g_s6
      // A load's data arrives from memory while it sits in S6.
      assign eff_value[gi] = load_q[gi] ? mem_rdata_i : value_q[gi];
      assign ready[gi]     = 1'b1;
    end else if (gi == 1) begin : g_s5
      assign eff_value[gi] = value_q[gi];
      assign ready[gi]     = !load_q[gi];
    end else begin : g_s7
      // S7 writes the register file this cycle but the write is not
      // visible to stage-3 reads, so it must still be forwarded.
      assign eff_value[gi] = value_q[gi];
      assign ready[gi]     = 1'b1;
    end
  end

  logic [4:0] src_rs  [2];
  logic       src_use [2];

  assign src_rs[0]  = id_rs1_i;
  assign src_rs[1]  = id_rs2_i;
  assign src_use[0] = id_uses_rs1_i;
  assign src_use[1] = id_uses_rs2_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    logic [NSLOT-1:0] hit;
    logic             byp;
    logic             haz;
    logic [31:0]      val;

    for (genvar gs = 0; gs < NSLOT; gs++) begin : g_hit
      assign hit[gs] = id_valid_i && src_use[gi] && (src_rs[gi] != 5'd0) &&
                       valid_q[gs] && (rd_q[gs] == src_rs[gi]);
    end

    // Scan oldest to youngest so the youngest hit is the last writer.
    always_comb begin
      byp = 1'b0;
      haz = 1'b0;
      val = '0;
      for (int k = NSLOT - 1; k >= 0; k--) begin
        if (hit[k]) begin
          byp = ready[k];
          haz = !ready[k];
          val = ready[k] ? eff_value[k] : 32'd0;
        end
      end
    end
  end

  assign bypass_o           = {g_src[1].byp, g_src[0].byp};
  assign rs1_bypass_value_o = g_src[0].val;
  assign rs2_bypass_value_o = g_src[1].val;
  assign hazard_stall_o     = g_src[0].haz | g_src[1].haz;
  assign hazard_count_o     = count_q;

  always_comb begin
    for (int k = 0; k < NSLOT; k++) begin
      valid_d[k] = valid_q[k];
      rd_d[k]    = rd_q[k];
      load_d[k]  = load_q[k];
      value_d[k] = value_q[k];
    end
    count_d = count_q;

    if (!stall_i) begin
      // A held stage-3 instruction enters S4 as a bubble.
      valid_d[0] = id_valid_i && id_writes_rd_i && (id_rd_i != 5'd0) &&
                   !hazard_stall_o;
      rd_d[0]    = id_rd_i;
      load_d[0]  = id_is_load_i;
      value_d[0] = '0;

      valid_d[1] = valid_q[0];
      rd_d[1]    = rd_q[0];
      load_d[1]  = load_q[0];
      value_d[1] = eval_i;

      valid_d[2] = valid_q[1];
      rd_d[2]    = rd_q[1];
      load_d[2]  = load_q[1];
      value_d[2] = value_q[1];

      // Captures load data when the S6 entry is a load.
      valid_d[3] = valid_q[2];
      rd_d[3]    = rd_q[2];
      load_d[3]  = load_q[2];
      value_d[3] = eff_value[2];

      if (hazard_stall_o && (count_q != 16'hFFFF)) begin
        count_d = count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NSLOT; k++) begin
        valid_q[k] <= 1'b0;
        rd_q[k]    <= '0;
        load_q[k]  <= 1'b0;
        value_q[k] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int k = 0; k < NSLOT; k++) begin
        valid_q[k] <= valid_d[k];
        rd_q[k]    <= rd_d[k];
        load_q[k]  <= load_d[k];
        value_q[k] <= value_d[k];
      end
      count_q <= count_d;
    end
  end

endmodule
